// File: rtl/txt_cell_pixel_gen.sv
// txt_cell_pixel_gen: text-mode display pixel generator.
// Turns the beam position into a cell fetch, then a glyph fetch, and emits one
// RGB444 pixel per clock with a fixed latency of 3 + CELL_LAT + FONT_LAT clocks.
// Optional feature macro: TXT_CURSOR_EN (adds the cursorIx port and a flashing
// two-line cursor drawn over the matching cell).
module txt_cell_pixel_gen #(
    parameter int COLS     = 80,
    parameter int ROWS     = 50,
    parameter int CELL_LAT = 2,
    parameter int FONT_LAT = 2
) (
    input  logic         clock,
    input  logic         reset,
    input  logic [9:0]   beamX,
    input  logic [9:0]   beamY,
    input  logic         beamActive,
    input  logic         frameStart,
    output logic [13:0]  pixCellIx,
    input  logic [127:0] cellData,
    output logic [15:0]  fontGlyph,
    input  logic [63:0]  fontData,
    output logic [11:0]  pixRgb,
    output logic         pixValid
`ifdef TXT_CURSOR_EN
    ,
    input  logic [13:0]  cursorIx
`endif
);

    localparam logic [13:0] COLS_W = 14'(COLS);
    localparam logic [9:0]  COLS_L = 10'(COLS);
    localparam logic [9:0]  ROWS_L = 10'(ROWS);

    // Per-pixel side-band travelling alongside the memory fetches.
    typedef struct packed {
        logic       active;
        logic       in_range;
        logic [2:0] x_lo;
        logic [2:0] y_lo;
`ifdef TXT_CURSOR_EN
        logic       cur_match;
`endif
    } side_t;

    // Side-band plus decoded cell attributes, waiting for the font row.
    typedef struct packed {
        side_t      sb;
        logic [5:0] fg;
        logic [5:0] bg;
        logic       blink;
        logic       underline;
    } attr_t;

    logic [6:0]  col;
    logic [6:0]  row;
    logic [13:0] cell_ix_d;
    logic [13:0] cell_ix_q;
    side_t       sb0_d;
    side_t       sb_q [0:CELL_LAT];

    attr_t       s1_d;
    attr_t       s1_q [0:FONT_LAT];
    logic [15:0] glyph_d;
    logic [15:0] glyph_q;

    attr_t       s2;
    logic [2:0]  row_sel;
    logic [7:0]  font_row;
    logic        font_bit;
    logic [5:0]  colour;
    logic [11:0] rgb_d;
    logic [11:0] rgb_q;
    logic        valid_d;
    logic        valid_q;

    logic [5:0]  frame_cnt_d;
    logic [5:0]  frame_cnt_q;

    // Upper cell-word bits carry nothing this block uses.
    logic        unused_cell_bits;
    assign unused_cell_bits = ^cellData[127:31];

    // S0: beam position to cell index and side-band bits.
    always_comb begin
        col            = beamX[9:3];
        row            = beamY[9:3];
        cell_ix_d      = {7'd0, row} * COLS_W + {7'd0, col};
        sb0_d          = '0;
        sb0_d.active   = beamActive;
        sb0_d.in_range = ({3'd0, col} < COLS_L) && ({3'd0, row} < ROWS_L);
        sb0_d.x_lo     = beamX[2:0];
        sb0_d.y_lo     = beamY[2:0];
`ifdef TXT_CURSOR_EN
        sb0_d.cur_match = (cell_ix_d == cursorIx);
`endif
    end

    // S0 registers and the side-band delay line covering the cell fetch.
    always_ff @(posedge clock) begin
        if (reset) begin
            cell_ix_q <= '0;
            for (int i = 0; i <= CELL_LAT; i++) sb_q[i] <= '0;
        end else begin
            cell_ix_q <= cell_ix_d;
            sb_q[0]   <= sb0_d;
            for (int i = 1; i <= CELL_LAT; i++) sb_q[i] <= sb_q[i-1];
        end
    end

    // S1: cell word arrives; decode colours, apply reverse video, pick glyph.
    always_comb begin
        s1_d           = '0;
        s1_d.sb        = sb_q[CELL_LAT];
        s1_d.blink     = cellData[28];
        s1_d.underline = cellData[29];
        if (cellData[30]) begin
            s1_d.fg = cellData[27:22];
            s1_d.bg = cellData[21:16];
        end else begin
            s1_d.fg = cellData[21:16];
            s1_d.bg = cellData[27:22];
        end
        glyph_d = cellData[15:0];
    end

    // S1 registers and the attribute delay line covering the font fetch.
    always_ff @(posedge clock) begin
        if (reset) begin
            glyph_q <= '0;
            for (int i = 0; i <= FONT_LAT; i++) s1_q[i] <= '0;
        end else begin
            glyph_q <= glyph_d;
            s1_q[0] <= s1_d;
            for (int i = 1; i <= FONT_LAT; i++) s1_q[i] <= s1_q[i-1];
        end
    end

    // S2: font row arrives; select the pixel bit and resolve the final colour.
    always_comb begin
        s2       = s1_q[FONT_LAT];
        row_sel  = ~s2.sb.y_lo;
        font_row = fontData[{row_sel, 3'b111} -: 8];
        font_bit = font_row[~s2.sb.x_lo];
        colour   = font_bit ? s2.fg : s2.bg;
        if (s2.underline && (s2.sb.y_lo == 3'd7)) colour = s2.fg;
        if (s2.blink && frame_cnt_q[5]) colour = s2.bg;
`ifdef TXT_CURSOR_EN
        if (s2.sb.cur_match && frame_cnt_q[4] && (s2.sb.y_lo[2:1] == 2'b11)) colour = s2.fg;
`endif
        rgb_d = 12'h000;
        if (s2.sb.active && s2.sb.in_range) begin
            rgb_d = {colour[5:4], colour[5:4], colour[3:2], colour[3:2],
                     colour[1:0], colour[1:0]};
        end
        valid_d = s2.sb.active;
    end

    // Frame counter drives the blink and cursor phases.
    always_comb begin
        frame_cnt_d = frame_cnt_q;
        if (frameStart) frame_cnt_d = frame_cnt_q + 6'd1;
    end

    // Output registers and frame counter.
    always_ff @(posedge clock) begin
        if (reset) begin
            rgb_q       <= '0;
            valid_q     <= 1'b0;
            frame_cnt_q <= '0;
        end else begin
            rgb_q       <= rgb_d;
            valid_q     <= valid_d;
            frame_cnt_q <= frame_cnt_d;
        end
    end

    assign pixCellIx = cell_ix_q;
    assign fontGlyph = glyph_q;
    assign pixRgb    = rgb_q;
    assign pixValid  = valid_q;

endmodule

// File: tb/tb_txt_cell_pixel_gen.sv
// Directed testbench for txt_cell_pixel_gen with behavioural cell/font memories.
module tb_txt_cell_pixel_gen;

    logic         clk;
    logic         reset;
    logic [9:0]   beamX;
    logic [9:0]   beamY;
    logic         beamActive;
    logic         frameStart;
    logic [13:0]  pixCellIx;
    logic [127:0] cellData;
    logic [15:0]  fontGlyph;
    logic [63:0]  fontData;
    logic [11:0]  pixRgb;
    logic         pixValid;
    logic [13:0]  cursorIx;

    int checks = 0;
    int errors = 0;
    int tb_fc  = 0;

    logic [127:0] cell_mem [0:16383];
    logic [63:0]  font_mem [0:255];
    logic [127:0] cell_p1, cell_p2;
    logic [63:0]  font_p1, font_p2;

    txt_cell_pixel_gen dut (
        .clock      (clk),
        .reset      (reset),
        .beamX      (beamX),
        .beamY      (beamY),
        .beamActive (beamActive),
        .frameStart (frameStart),
        .pixCellIx  (pixCellIx),
        .cellData   (cellData),
        .fontGlyph  (fontGlyph),
        .fontData   (fontData),
        .pixRgb     (pixRgb),
        .pixValid   (pixValid)
`ifdef TXT_CURSOR_EN
        ,
        .cursorIx   (cursorIx)
`endif
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Two-clock read latency memories.
    always @(posedge clk) begin
        cell_p1 <= cell_mem[pixCellIx];
        cell_p2 <= cell_p1;
        font_p1 <= font_mem[fontGlyph[7:0]];
        font_p2 <= font_p1;
    end
    assign cellData = cell_p2;
    assign fontData = font_p2;

    initial begin
        #500000;
        $display("FAIL watchdog: time limit reached, expected the bench to finish");
        $fatal(1);
    end

    function automatic logic [127:0] make_cell(input logic [15:0] glyph, input logic [5:0] fg,
                                               input logic [5:0] bg, input logic blink,
                                               input logic ul, input logic rev);
        return {97'd0, rev, ul, blink, bg, fg, glyph};
    endfunction

    task automatic run_px(input logic [9:0] x, input logic [9:0] y, input logic act,
                          output logic [11:0] rgb, output logic vld);
        beamX = x;
        beamY = y;
        beamActive = act;
        @(posedge clk);
        #1;
        beamActive = 1'b0;
        repeat (6) @(posedge clk);
        #1;
        rgb = pixRgb;
        vld = pixValid;
    endtask

    task automatic pulse_frames(input int n);
        for (int i = 0; i < n; i++) begin
            frameStart = 1'b1;
            @(posedge clk);
            #1;
            frameStart = 1'b0;
            tb_fc = (tb_fc + 1) % 64;
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        beamActive = 1'b1;
        beamX = 10'd0;
        beamY = 10'd0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (pixRgb !== 12'h000 || pixValid !== 1'b0 || pixCellIx !== 14'd0 || fontGlyph !== 16'd0) begin
            errors++;
            $display("FAIL reset_state: rgb=%h vld=%b ix=%0d glyph=%h, expected all zero",
                     pixRgb, pixValid, pixCellIx, fontGlyph);
        end
        reset = 1'b0;
        tb_fc = 0;
        for (int k = 1; k <= 7; k++) begin
            @(posedge clk);
            #1;
            checks++;
            if (pixValid !== 1'(k == 7) || pixRgb !== 12'h000) begin
                errors++;
                $display("FAIL reset_latency clk%0d: vld=%b rgb=%h, expected vld=%b rgb=000",
                         k, pixValid, pixRgb, k == 7);
            end
        end
        beamActive = 1'b0;
        repeat (8) @(posedge clk);
        #1;
    endtask

    task automatic test_index();
        logic [11:0] rgb;
        logic vld;
        beamX = 10'd17;
        beamY = 10'd9;
        beamActive = 1'b1;
        @(posedge clk);
        #1;
        beamActive = 1'b0;
        checks++;
        if (pixCellIx !== 14'd82) begin
            errors++;
            $display("FAIL cell_index: pixCellIx=%0d, expected 82", pixCellIx);
        end
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (fontGlyph !== 16'h0041) begin
            errors++;
            $display("FAIL glyph_issue: fontGlyph=%h, expected 0041", fontGlyph);
        end
        repeat (8) @(posedge clk);
        #1;
        run_px(10'd17, 10'd9, 1'b1, rgb, vld);
        checks++;
        if (rgb !== 12'hFFF || vld !== 1'b1) begin
            errors++;
            $display("FAIL glyph_fg x17: rgb=%h vld=%b, expected fff 1", rgb, vld);
        end
        run_px(10'd16, 10'd9, 1'b1, rgb, vld);
        checks++;
        if (rgb !== 12'h000 || vld !== 1'b1) begin
            errors++;
            $display("FAIL glyph_bg x16: rgb=%h vld=%b, expected 000 1", rgb, vld);
        end
        run_px(10'd18, 10'd9, 1'b1, rgb, vld);
        checks++;
        if (rgb !== 12'h000) begin
            errors++;
            $display("FAIL glyph_bg x18: rgb=%h, expected 000", rgb);
        end
        run_px(10'd17, 10'd8, 1'b1, rgb, vld);
        checks++;
        if (rgb !== 12'h000) begin
            errors++;
            $display("FAIL glyph_row0 y8: rgb=%h, expected 000", rgb);
        end
        run_px(10'd17, 10'd9, 1'b0, rgb, vld);
        checks++;
        if (rgb !== 12'h000 || vld !== 1'b0) begin
            errors++;
            $display("FAIL inactive: rgb=%h vld=%b, expected 000 0", rgb, vld);
        end
    endtask

    task automatic test_reverse_colour();
        logic [11:0] rgb;
        logic vld;
        run_px(10'd25, 10'd0, 1'b1, rgb, vld);
        checks++;
        if (rgb !== 12'hF00) begin
            errors++;
            $display("FAIL reverse_bit0: rgb=%h, expected f00", rgb);
        end
        run_px(10'd24, 10'd0, 1'b1, rgb, vld);
        checks++;
        if (rgb !== 12'h00F) begin
            errors++;
            $display("FAIL reverse_bit1: rgb=%h, expected 00f", rgb);
        end
        run_px(10'd50, 10'd3, 1'b1, rgb, vld);
        checks++;
        if (rgb !== 12'hA5F) begin
            errors++;
            $display("FAIL expand_fg: rgb=%h, expected a5f", rgb);
        end
        run_px(10'd61, 10'd4, 1'b1, rgb, vld);
        checks++;
        if (rgb !== 12'h5A0) begin
            errors++;
            $display("FAIL expand_bg: rgb=%h, expected 5a0", rgb);
        end
    endtask

    task automatic test_underline();
        logic [11:0] rgb;
        logic vld;
        run_px(10'd33, 10'd7, 1'b1, rgb, vld);
        checks++;
        if (rgb !== 12'hFFF) begin
            errors++;
            $display("FAIL underline_r7: rgb=%h, expected fff", rgb);
        end
        run_px(10'd33, 10'd6, 1'b1, rgb, vld);
        checks++;
        if (rgb !== 12'h000) begin
            errors++;
            $display("FAIL underline_r6: rgb=%h, expected 000", rgb);
        end
    endtask

    task automatic test_out_of_range();
        logic [11:0] rgb;
        logic vld;
        run_px(10'd3, 10'd8, 1'b1, rgb, vld);
        checks++;
        if (rgb !== 12'hFFF || vld !== 1'b1) begin
            errors++;
            $display("FAIL in_range_ref: rgb=%h vld=%b, expected fff 1", rgb, vld);
        end
        run_px(10'd640, 10'd0, 1'b1, rgb, vld);
        checks++;
        if (rgb !== 12'h000 || vld !== 1'b1) begin
            errors++;
            $display("FAIL col80: rgb=%h vld=%b, expected 000 1", rgb, vld);
        end
        run_px(10'd2, 10'd400, 1'b1, rgb, vld);
        checks++;
        if (rgb !== 12'h000 || vld !== 1'b1) begin
            errors++;
            $display("FAIL row50: rgb=%h vld=%b, expected 000 1", rgb, vld);
        end
    endtask

    task automatic test_back_to_back();
        int xs [10] = '{16, 17, 18, 19, 20, 21, 22, 23, 24, 25};
        int ys [10] = '{9, 9, 9, 9, 9, 9, 9, 9, 0, 0};
        logic [11:0] ex [10] = '{12'h000, 12'hFFF, 12'h000, 12'h000, 12'h000,
                                 12'h000, 12'h000, 12'h000, 12'h00F, 12'hF00};
        for (int i = 0; i < 17; i++) begin
            if (i < 10) begin
                beamX = 10'(xs[i]);
                beamY = 10'(ys[i]);
                beamActive = 1'b1;
            end else begin
                beamActive = 1'b0;
            end
            @(posedge clk);
            #1;
            if (i >= 6 && i < 16) begin
                checks++;
                if (pixRgb !== ex[i-6] || pixValid !== 1'b1) begin
                    errors++;
                    $display("FAIL stream px%0d: rgb=%h vld=%b, expected %h 1",
                             i - 6, pixRgb, pixValid, ex[i-6]);
                end
            end
        end
        repeat (4) @(posedge clk);
        #1;
    endtask

    task automatic test_blink();
        logic [11:0] rgb;
        logic vld;
        run_px(10'd40, 10'd0, 1'b1, rgb, vld);
        checks++;
        if (rgb !== 12'hFFF) begin
            errors++;
            $display("FAIL blink_phase0: rgb=%h, expected fff", rgb);
        end
        pulse_frames(32);
        run_px(10'd40, 10'd0, 1'b1, rgb, vld);
        checks++;
        if (rgb !== 12'h0F0) begin
            errors++;
            $display("FAIL blink_phase1: rgb=%h, expected 0f0", rgb);
        end
        run_px(10'd17, 10'd9, 1'b1, rgb, vld);
        checks++;
        if (rgb !== 12'hFFF) begin
            errors++;
            $display("FAIL no_blink_cell: rgb=%h, expected fff", rgb);
        end
        pulse_frames(32);
        run_px(10'd40, 10'd0, 1'b1, rgb, vld);
        checks++;
        if (rgb !== 12'hFFF) begin
            errors++;
            $display("FAIL blink_wrap: rgb=%h, expected fff", rgb);
        end
    endtask

`ifdef TXT_CURSOR_EN
    task automatic test_cursor();
        logic [11:0] rgb;
        logic vld;
        cell_mem[82] = make_cell(16'h0044, 6'h3F, 6'h00, 1'b0, 1'b0, 1'b0);
        cursorIx = 14'd82;
        pulse_frames(((16 - tb_fc) % 64 + 64) % 64);
        run_px(10'd17, 10'd14, 1'b1, rgb, vld);
        checks++;
        if (rgb !== 12'hFFF) begin
            errors++;
            $display("FAIL cursor_r6: rgb=%h, expected fff", rgb);
        end
        run_px(10'd20, 10'd15, 1'b1, rgb, vld);
        checks++;
        if (rgb !== 12'hFFF) begin
            errors++;
            $display("FAIL cursor_r7: rgb=%h, expected fff", rgb);
        end
        run_px(10'd17, 10'd13, 1'b1, rgb, vld);
        checks++;
        if (rgb !== 12'h000) begin
            errors++;
            $display("FAIL cursor_r5: rgb=%h, expected 000", rgb);
        end
        pulse_frames(16);
        run_px(10'd17, 10'd15, 1'b1, rgb, vld);
        checks++;
        if (rgb !== 12'h000) begin
            errors++;
            $display("FAIL cursor_off: rgb=%h, expected 000", rgb);
        end
        cursorIx = 14'h3FFF;
        cell_mem[82] = make_cell(16'h0041, 6'h3F, 6'h00, 1'b0, 1'b0, 1'b0);
    endtask
`endif

    task automatic test_reset_flush();
        logic [11:0] rgb;
        logic vld;
        pulse_frames(((32 - tb_fc) % 64 + 64) % 64);
        run_px(10'd40, 10'd0, 1'b1, rgb, vld);
        checks++;
        if (rgb !== 12'h0F0) begin
            errors++;
            $display("FAIL flush_pre: rgb=%h, expected 0f0", rgb);
        end
        beamX = 10'd40;
        beamY = 10'd0;
        beamActive = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        beamActive = 1'b0;
        tb_fc = 0;
        for (int k = 0; k < 9; k++) begin
            @(posedge clk);
            #1;
            checks++;
            if (pixValid !== 1'b0 || pixRgb !== 12'h000) begin
                errors++;
                $display("FAIL flush clk%0d: vld=%b rgb=%h, expected 0 000", k, pixValid, pixRgb);
            end
        end
        run_px(10'd40, 10'd0, 1'b1, rgb, vld);
        checks++;
        if (rgb !== 12'hFFF || vld !== 1'b1) begin
            errors++;
            $display("FAIL flush_post: rgb=%h vld=%b, expected fff 1", rgb, vld);
        end
    endtask

    initial begin
        reset = 1'b1;
        beamX = '0;
        beamY = '0;
        beamActive = 1'b0;
        frameStart = 1'b0;
        cursorIx = 14'h3FFF;
        for (int i = 0; i < 16384; i++) cell_mem[i] = '0;
        for (int i = 0; i < 256; i++) font_mem[i] = '0;
        font_mem[8'h41] = 64'h0040_0000_0000_0000;
        font_mem[8'h42] = 64'h8000_0000_0000_0000;
        font_mem[8'h43] = 64'hFFFF_FFFF_FFFF_FFFF;
        cell_mem[82]   = make_cell(16'h0041, 6'h3F, 6'h00, 1'b0, 1'b0, 1'b0);
        cell_mem[3]    = make_cell(16'h0042, 6'h30, 6'h03, 1'b0, 1'b0, 1'b1);
        cell_mem[4]    = make_cell(16'h0044, 6'h3F, 6'h00, 1'b0, 1'b1, 1'b0);
        cell_mem[5]    = make_cell(16'h0043, 6'h3F, 6'h0C, 1'b1, 1'b0, 1'b0);
        cell_mem[6]    = make_cell(16'h0043, 6'b10_01_11, 6'h00, 1'b0, 1'b0, 1'b0);
        cell_mem[7]    = make_cell(16'h0044, 6'h3F, 6'b01_10_00, 1'b0, 1'b0, 1'b0);
        cell_mem[80]   = make_cell(16'h0043, 6'h3F, 6'h00, 1'b0, 1'b0, 1'b0);
        cell_mem[4000] = make_cell(16'h0043, 6'h3F, 6'h00, 1'b0, 1'b0, 1'b0);

        test_reset();
        test_index();
        test_reverse_colour();
        test_underline();
        test_out_of_range();
        test_back_to_back();
        test_blink();
`ifdef TXT_CURSOR_EN
        test_cursor();
`endif
        test_reset_flush();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
